// File: rtl/rca_word_serial_ctrl.sv
// Word-serial wrapper around an external N-bit ripple-carry adder: chains carry
// between LSW-first operand words and registers each sum word into an output stream.
module rca_word_serial_ctrl #(
   parameter int N         = 4,
   parameter int MAX_WORDS = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         cin_init,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] in_a,
   input  logic [N-1:0] in_b,
   input  logic         in_first,
   input  logic         in_last,
   output logic [N-1:0] rca_a,
   output logic [N-1:0] rca_b,
   output logic         rca_cin,
   input  logic [N-1:0] rca_sum,
   input  logic         rca_cout,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] out_sum,
   output logic         out_last,
   output logic         out_cout,
   output logic         out_ovf,
   output logic         out_err
);

   localparam int CW = $clog2(MAX_WORDS + 1);

   typedef enum logic {IDLE, ACTIVE} state_t;

   state_t        state, state_nx;
   logic          carry_q;
   logic [CW-1:0] count, count_nx, count_inc;
   logic          accept, restart, word_last, err_nx, ovf_nx;

   assign in_ready = !out_valid | out_ready;
   assign accept   = in_valid & in_ready;

   // A fresh packet (from IDLE or an early in_first) always restarts the carry chain.
   assign restart  = (state == IDLE) | in_first;
   assign rca_a    = in_a;
   assign rca_b    = in_b;
   assign rca_cin  = restart ? cin_init : carry_q;

   always_comb begin
      count_inc = restart ? CW'(1) : count + 1'b1;
      word_last = in_last | (count_inc == CW'(MAX_WORDS));
      err_nx    = ((state == ACTIVE) & in_first) |
                  (!in_last & (count_inc == CW'(MAX_WORDS)));
      ovf_nx    = word_last & (in_a[N-1] == in_b[N-1]) & (rca_sum[N-1] != in_a[N-1]);
      state_nx  = state;
      count_nx  = count;
      if (accept) begin
         if (word_last) begin
            state_nx = IDLE;
            count_nx = '0;
         end else begin
            state_nx = ACTIVE;
            count_nx = count_inc;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         count     <= '0;
         carry_q   <= 1'b0;
         out_valid <= 1'b0;
         out_sum   <= '0;
         out_last  <= 1'b0;
         out_cout  <= 1'b0;
         out_ovf   <= 1'b0;
         out_err   <= 1'b0;
      end else begin
         state <= state_nx;
         count <= count_nx;
         if (accept) begin
            carry_q   <= rca_cout;
            out_valid <= 1'b1;
            out_sum   <= rca_sum;
            out_last  <= word_last;
            out_cout  <= word_last & rca_cout;
            out_ovf   <= ovf_nx;
            out_err   <= err_nx;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_rca_word_serial_ctrl.sv
// Directed bench for rca_word_serial_ctrl; includes a behavioural ripple-carry adder.
module tb_rca_word_serial_ctrl;

   localparam int N = 4;
   localparam int MAX_WORDS = 4;

   logic         clk = 1'b0;
   logic         rst, cin_init, in_valid, in_ready, in_first, in_last;
   logic [N-1:0] in_a, in_b, rca_a, rca_b, rca_sum, out_sum;
   logic         rca_cin, rca_cout, out_valid, out_ready, out_last, out_cout, out_ovf, out_err;
   logic [N:0]   add_full;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   assign add_full = {1'b0, rca_a} + {1'b0, rca_b} + {{N{1'b0}}, rca_cin};
   assign rca_sum  = add_full[N-1:0];
   assign rca_cout = add_full[N];

   rca_word_serial_ctrl #(.N(N), .MAX_WORDS(MAX_WORDS)) dut (
      .clk(clk), .rst(rst), .cin_init(cin_init),
      .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
      .in_first(in_first), .in_last(in_last),
      .rca_a(rca_a), .rca_b(rca_b), .rca_cin(rca_cin),
      .rca_sum(rca_sum), .rca_cout(rca_cout),
      .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
      .out_last(out_last), .out_cout(out_cout), .out_ovf(out_ovf), .out_err(out_err)
   );

   task automatic drive(input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic first, input logic last, input logic cin);
      @(negedge clk);
      in_a = a; in_b = b; in_first = first; in_last = last; cin_init = cin;
      in_valid = 1'b1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic first, input logic last, input logic cin);
      drive(a, b, first, last, cin);
      tick();
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; cin_init = 1'b0;
      in_a = '0; in_b = '0; in_first = 1'b0; in_last = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({out_valid, out_sum, out_last, out_cout, out_ovf, out_err} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got valid=%b sum=%h last=%b cout=%b ovf=%b err=%b, want all 0",
                  out_valid, out_sum, out_last, out_cout, out_ovf, out_err);
      end
      rst = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
      end
   endtask

   task automatic test_single_word();
      send(4'h1, 4'h2, 1'b1, 1'b1, 1'b0);
      checks++;
      if ({out_valid, out_sum, out_last, out_cout, out_ovf, out_err} !== {1'b1, 4'h3, 1'b1, 1'b0, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL single_word: got valid=%b sum=%h last=%b cout=%b ovf=%b err=%b, want 1 3 1 0 0 0",
                  out_valid, out_sum, out_last, out_cout, out_ovf, out_err);
      end
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++; $display("FAIL single_word_drain: out_valid got %b want 0", out_valid);
      end
   endtask

   task automatic test_two_word();
      drive(4'hF, 4'h1, 1'b1, 1'b0, 1'b0);
      #1;
      checks++;
      if (rca_cin !== 1'b0) begin
         errors++; $display("FAIL two_word_cin0: rca_cin got %b want 0", rca_cin);
      end
      tick();
      checks++;
      if ({out_valid, out_sum, out_last, out_cout} !== {1'b1, 4'h0, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL two_word_w0: got valid=%b sum=%h last=%b cout=%b, want 1 0 0 0",
                  out_valid, out_sum, out_last, out_cout);
      end
      drive(4'h0, 4'h0, 1'b0, 1'b1, 1'b0);
      #1;
      checks++;
      if (rca_cin !== 1'b1) begin
         errors++; $display("FAIL two_word_cin1: rca_cin got %b want 1", rca_cin);
      end
      tick();
      in_valid = 1'b0;
      checks++;
      if ({out_valid, out_sum, out_last, out_cout, out_ovf, out_err} !== {1'b1, 4'h1, 1'b1, 1'b0, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL two_word_w1: got valid=%b sum=%h last=%b cout=%b ovf=%b err=%b, want 1 1 1 0 0 0",
                  out_valid, out_sum, out_last, out_cout, out_ovf, out_err);
      end
   endtask

   task automatic test_flags();
      send(4'h7, 4'h1, 1'b1, 1'b1, 1'b0);
      checks++;
      if ({out_sum, out_cout, out_ovf} !== {4'h8, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL ovf_pos: got sum=%h cout=%b ovf=%b, want 8 0 1", out_sum, out_cout, out_ovf);
      end
      send(4'hF, 4'hF, 1'b1, 1'b1, 1'b1);
      checks++;
      if ({out_sum, out_cout, out_ovf} !== {4'hF, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL cout_full: got sum=%h cout=%b ovf=%b, want f 1 0", out_sum, out_cout, out_ovf);
      end
   endtask

   task automatic test_back_to_back();
      send(4'h2, 4'h3, 1'b1, 1'b1, 1'b0);
      @(negedge clk);
      out_ready = 1'b0;
      in_a = 4'h4; in_b = 4'h4; in_first = 1'b1; in_last = 1'b1; cin_init = 1'b0;
      in_valid = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b0) begin
         errors++; $display("FAIL stall_in_ready: got %b want 0", in_ready);
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if ({out_valid, out_sum} !== {1'b1, 4'h5}) begin
            errors++;
            $display("FAIL stall_hold[%0d]: got valid=%b sum=%h, want 1 5", i, out_valid, out_sum);
         end
      end
      @(negedge clk);
      out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      checks++;
      if ({out_valid, out_sum} !== {1'b1, 4'h8}) begin
         errors++;
         $display("FAIL b2b_replace: got valid=%b sum=%h, want 1 8", out_valid, out_sum);
      end
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++; $display("FAIL b2b_drain: out_valid got %b want 0", out_valid);
      end
   endtask

   task automatic test_max_words();
      // F+1 leaves carry_q=1, so a reused carry would show up as sum=1 after the forced end.
      for (int i = 0; i < 4; i++) begin
         send(4'hF, 4'h1, (i == 0), 1'b0, 1'b0);
         checks++;
         if ({out_sum, out_last, out_err, out_cout} !==
             {(i == 0) ? 4'h0 : 4'h1, (i == 3), (i == 3), (i == 3)}) begin
            errors++;
            $display("FAIL max_words[%0d]: got sum=%h last=%b err=%b cout=%b", i,
                     out_sum, out_last, out_err, out_cout);
         end
      end
      for (int i = 0; i < 4; i++) begin
         send(4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
         checks++;
         if ({out_sum, out_last, out_err} !== {4'h0, (i == 3), (i == 3)}) begin
            errors++;
            $display("FAIL max_restart[%0d]: got sum=%h last=%b err=%b, want 0 %b %b", i,
                     out_sum, out_last, out_err, (i == 3), (i == 3));
         end
      end
   endtask

   task automatic test_async_reset();
      send(4'hF, 4'hF, 1'b1, 1'b0, 1'b0);
      send(4'hF, 4'hF, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if ({out_valid, out_sum, out_last, out_cout, out_ovf, out_err} !== '0) begin
         errors++;
         $display("FAIL async_reset: got valid=%b sum=%h last=%b cout=%b ovf=%b err=%b, want all 0",
                  out_valid, out_sum, out_last, out_cout, out_ovf, out_err);
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++; $display("FAIL async_reset_ready: got %b want 1", in_ready);
      end
      send(4'h5, 4'h3, 1'b0, 1'b1, 1'b0);
      checks++;
      if ({out_valid, out_sum, out_last, out_err} !== {1'b1, 4'h8, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL post_reset_word: got valid=%b sum=%h last=%b err=%b, want 1 8 1 0",
                  out_valid, out_sum, out_last, out_err);
      end
   endtask

   task automatic test_first_abandon();
      send(4'hF, 4'h1, 1'b1, 1'b0, 1'b0);
      send(4'h3, 4'h0, 1'b1, 1'b1, 1'b0);
      checks++;
      if ({out_sum, out_last, out_err} !== {4'h3, 1'b1, 1'b1}) begin
         errors++;
         $display("FAIL first_abandon: got sum=%h last=%b err=%b, want 3 1 1", out_sum, out_last, out_err);
      end
   endtask

   initial begin
      test_reset();
      test_single_word();
      test_two_word();
      test_flags();
      test_back_to_back();
      test_max_words();
      test_first_abandon();
      test_async_reset();
      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
